baud_gen: RTL and testbench
===========================

Name: baud_gen

Overview:
- Parametrised baud-rate generator for the UART.
- Registers the 4-bit baud selection and derives the bit-time divisor from the CLK_FREQ_HZ parameter, not a fixed 100 MHz table.
- Runs two free-running counters:
  - a bit-rate tick for the transmitter;
  - an oversampled tick for the receiver, with restart for start-bit alignment.
- Flags unsupported codes instead of leaving them undefined.

Parameters:
- CLK_FREQ_HZ, 100_000_000, system clock frequency in Hz.
- OVERSAMPLE, 16, rx ticks per bit time; must be >= 2.
- CNT_W, 19, counter/divisor width; must satisfy 2^CNT_W > round(CLK_FREQ_HZ/300).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- baud  input  4  rate select: 0=300, 1=1200, 2=2400, 3=4800, 4=9600, 5=19200, 6=38400, 7=57600, 8=115200, 9=230400, 10=460800, 11=921600; 12-15 unsupported.
- enable  input  1  counters advance only while high; while low, counters hold and ticks are 0.
- rx_restart  input  1  synchronous clear of rx counter only (start-bit edge detected).
- k  output  CNT_W  registered bit-time divisor for the current code.
- baud_valid  output  1  registered; 1 when code 0-11.
- tx_tick  output  1  one-cycle pulse per bit time.
- rx_tick  output  1  one-cycle pulse per bit time / OVERSAMPLE.

Behaviour:
- Reset is asynchronous, active-high, on clk. Reset state:
  - tx_cnt = 0, rx_cnt = 0, k = 0, rx_div = 0, baud_valid = 0;
  - tx_tick = 0, rx_tick = 0;
  - baud_q = 4'hF, which forces a "change" on the first edge after release.
- Divisors are elaboration-time constants, round-half-up:
  - TX_DIV[i] = (CLK_FREQ_HZ + RATE[i]/2) / RATE[i];
  - RX_DIV[i] = (CLK_FREQ_HZ + RATE[i]*OVERSAMPLE/2) / (RATE[i]*OVERSAMPLE);
  - any RX_DIV below 1 clamps to 1.
- Change edge (baud != baud_q) does all of the following:
  - baud_q <= baud;
  - k <= TX_DIV, rx_div <= RX_DIV, baud_valid <= (baud < 12);
  - tx_cnt <= 0, rx_cnt <= 0;
  - tx_tick <= 0, rx_tick <= 0.
- Count edge (no change, enable = 1, baud_valid = 1):
  - tx: if tx_cnt == k-1 then tx_cnt <= 0 and tx_tick <= 1; otherwise tx_cnt++ and tx_tick <= 0.
  - rx: same rule with rx_div and rx_tick.
- Latency: first tx_tick is registered on the k-th count edge after a change edge, so tick period = k cycles exactly. Same for rx with rx_div.
- rx_restart = 1 on a count edge: rx_cnt <= 0, rx_tick <= 0. tx path is unaffected.
- rx_restart coincident with a change edge has no additional effect; both clear.
- enable = 0: counters hold their value, ticks <= 0. Counting resumes from the held value when enable returns.
- Invalid code (12-15): baud_valid = 0, k = 0, counters held at 0, ticks never assert.
- Divisor of 1 (rx at very high rates): tick asserted every enabled cycle.
- Counter compare uses CNT_W-bit unsigned arithmetic; the counter never exceeds divisor-1.

Decomposition:
- Package uart_pkg holds:
  - localparam BAUD_W = 4;
  - NUM_RATES = 12;
  - RATE table (integer array);
  - function div_round(clk, rate, os) for TX_DIV/RX_DIV computation.
- One sub-module, tick_counter, is natural and instantiated twice (tx, rx).
  - Ports: clk, reset, clr, en, div[CNT_W], tick.
  - Implements the count/compare/pulse rule above.

Test Plan:
- Reset asserted mid-count with baud=8 → all outputs 0 immediately (asynchronous); after release, k=868 and baud_valid=1 one edge later; first tx_tick 868 cycles after that edge.
- baud=8, enable=1, 100 MHz → tx_tick period 868 cycles, rx_tick period 54 cycles, every tick pulse exactly 1 cycle wide.
- baud=11 → k=109 (108.5 rounds up), rx period 7. baud=0 → k=333333, rx period 20833.
- Switch baud 4→8 mid-bit → k changes 10417→868 on that edge, no tick on it, next tx_tick exactly 868 cycles later.
- rx_restart pulsed 30 cycles into an rx period at baud=8 → next rx_tick 54 cycles after the restart edge; tx_tick spacing unchanged at 868.
- baud=13 → baud_valid=0, k=0, no ticks for 10000 cycles. Then baud=4 → k=10417, ticks resume. Separately, enable low for 100 cycles mid-count → tx period observed = 868+100.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART constants: baud code width, rate table
// and the rounding helper used to derive clock divisors.
package uart_pkg;

  localparam int BAUD_W    = 4;
  localparam int NUM_RATES = 12;

  localparam int RATE [NUM_RATES] = '{
    300, 1200, 2400, 4800, 9600, 19200,
    38400, 57600, 115200, 230400, 460800, 921600
  };

  // Round-half-up clk/(rate*os), never below 1
  function automatic longint div_round(
    input longint clk_hz,
    input longint rate,
    input longint os
  );
    longint d;
    longint q;
    d = rate * os;
    q = (clk_hz + d / 2) / d;
    if (q < 1) q = 1;
    return q;
  endfunction

endpackage

// File: rtl/tick_counter.sv
// Free-running modulo-div counter emitting a one-cycle
// tick each time it wraps; clr restarts the period.
module tick_counter #(
  parameter int CNT_W = 19
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] div,
  output logic             tick
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_last;

  assign w_last = div - CNT_W'(1);

  // Count to div-1, wrap and pulse; hold while disabled
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
      tick  <= 1'b0;
    end else if (clr) begin
      r_cnt <= '0;
      tick  <= 1'b0;
    end else if (en) begin
      if (r_cnt == w_last) begin
        r_cnt <= '0;
        tick  <= 1'b1;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
        tick  <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/baud_gen.sv
// UART baud generator: registers the rate code, looks up
// tx/rx divisors and drives the tx and oversampled rx ticks.
import uart_pkg::*;

module baud_gen #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int OVERSAMPLE  = 16,
  parameter int CNT_W       = 19
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [BAUD_W-1:0] baud,
  input  logic              enable,
  input  logic              rx_restart,
  output logic [CNT_W-1:0]  k,
  output logic              baud_valid,
  output logic              tx_tick,
  output logic              rx_tick
);

  logic [BAUD_W-1:0] r_baud_q;
  logic [CNT_W-1:0]  r_k;
  logic [CNT_W-1:0]  r_rx_div;
  logic              r_valid;
  logic [CNT_W-1:0]  w_tx_div;
  logic [CNT_W-1:0]  w_rx_div;
  logic              w_chg;
  logic              w_en;
  logic              w_rx_clr;

  assign w_chg    = (baud != r_baud_q);
  assign w_en     = enable & r_valid & ~w_chg;
  assign w_rx_clr = w_chg | rx_restart;

  // Constant divisor lookup; unsupported codes give 0
  always_comb begin
    w_tx_div = '0;
    w_rx_div = '0;
    for (int i = 0; i < NUM_RATES; i++) begin
      if (baud == BAUD_W'(i)) begin
        w_tx_div = CNT_W'(div_round(
          longint'(CLK_FREQ_HZ), longint'(RATE[i]),
          longint'(1)));
        w_rx_div = CNT_W'(div_round(
          longint'(CLK_FREQ_HZ), longint'(RATE[i]),
          longint'(OVERSAMPLE)));
      end
    end
  end

  // Latch divisors when the code changes; 4'hF forces a load
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_baud_q <= 4'hF;
      r_k      <= '0;
      r_rx_div <= '0;
      r_valid  <= 1'b0;
    end else if (w_chg) begin
      r_baud_q <= baud;
      r_k      <= w_tx_div;
      r_rx_div <= w_rx_div;
      r_valid  <= (baud < BAUD_W'(NUM_RATES));
    end
  end

  assign k          = r_k;
  assign baud_valid = r_valid;

  tick_counter #(.CNT_W(CNT_W)) u_tx (
    .clk   (clk),
    .reset (reset),
    .clr   (w_chg),
    .en    (w_en),
    .div   (r_k),
    .tick  (tx_tick)
  );

  tick_counter #(.CNT_W(CNT_W)) u_rx (
    .clk   (clk),
    .reset (reset),
    .clr   (w_rx_clr),
    .en    (w_en),
    .div   (r_rx_div),
    .tick  (rx_tick)
  );

endmodule

// File: tb/tb_baud_gen.sv
// Directed self-checking bench for baud_gen at 100 MHz,
// OVERSAMPLE=16, with hand-computed divisors and periods.
module tb_baud_gen;

  logic        clk;
  logic        reset;
  logic [3:0]  baud;
  logic        enable;
  logic        rx_restart;
  logic [18:0] k;
  logic        baud_valid;
  logic        tx_tick;
  logic        rx_tick;

  int errors = 0;
  int checks = 0;

  int ftx, stx, frx, srx, wide;

  baud_gen #(
    .CLK_FREQ_HZ (100_000_000),
    .OVERSAMPLE  (16),
    .CNT_W       (19)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .baud       (baud),
    .enable     (enable),
    .rx_restart (rx_restart),
    .k          (k),
    .baud_valid (baud_valid),
    .tx_tick    (tx_tick),
    .rx_tick    (rx_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs,
                     input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_baud(input logic [3:0] b);
    baud = b;
    step(1);
  endtask

  // Run n edges; report first two tick indices (-1 = none)
  // and count ticks that stayed high two samples in a row
  task automatic watch(input int n, output int f_tx,
                       output int s_tx, output int f_rx,
                       output int s_rx, output int w);
    logic ptx, prx;
    f_tx = -1; s_tx = -1; f_rx = -1; s_rx = -1; w = 0;
    ptx = 1'b0; prx = 1'b0;
    for (int i = 1; i <= n; i++) begin
      @(posedge clk);
      #1;
      if (tx_tick) begin
        if (f_tx < 0) f_tx = i;
        else if (s_tx < 0) s_tx = i;
        if (ptx) w++;
      end
      if (rx_tick) begin
        if (f_rx < 0) f_rx = i;
        else if (s_rx < 0) s_rx = i;
        if (prx) w++;
      end
      ptx = tx_tick;
      prx = rx_tick;
    end
  endtask

  initial begin
    reset = 1'b1; baud = 4'd8; enable = 1'b1; rx_restart = 1'b0;
    step(3);
    chk("rst_k", k, 0);
    chk("rst_valid", baud_valid, 0);
    chk("rst_ticks", {tx_tick, rx_tick}, 0);

    // Start counting, then assert reset asynchronously mid-count
    reset = 1'b0;
    step(300);
    #2 reset = 1'b1;
    #1;
    chk("async_k", k, 0);
    chk("async_valid", baud_valid, 0);
    chk("async_ticks", {tx_tick, rx_tick}, 0);
    step(2);
    reset = 1'b0;
    step(1);
    chk("rel_k", k, 868);
    chk("rel_valid", baud_valid, 1);
    watch(1800, ftx, stx, frx, srx, wide);
    chk("b8_first_tx", ftx, 868);
    chk("b8_tx_period", stx - ftx, 868);
    chk("b8_first_rx", frx, 54);
    chk("b8_rx_period", srx - frx, 54);
    chk("b8_width", wide, 0);

    // Highest rate: 108.5 rounds up, rx 7
    set_baud(4'd11);
    chk("b11_k", k, 109);
    watch(250, ftx, stx, frx, srx, wide);
    chk("b11_first_tx", ftx, 109);
    chk("b11_tx_period", stx - ftx, 109);
    chk("b11_rx_period", srx - frx, 7);
    chk("b11_width", wide, 0);

    // Lowest rate: widest divisor
    set_baud(4'd0);
    chk("b0_k", k, 333333);
    watch(42000, ftx, stx, frx, srx, wide);
    chk("b0_first_rx", frx, 20833);
    chk("b0_rx_period", srx - frx, 20833);
    chk("b0_no_tx", ftx, -1);

    // Switch 4 -> 8 mid-bit
    set_baud(4'd4);
    chk("b4_k", k, 10417);
    step(5000);
    set_baud(4'd8);
    chk("sw_k", k, 868);
    chk("sw_no_tick", tx_tick, 0);
    watch(900, ftx, stx, frx, srx, wide);
    chk("sw_first_tx", ftx, 868);

    // rx_restart 30 cycles into an rx period
    set_baud(4'd4);
    set_baud(4'd8);
    step(30);
    rx_restart = 1'b1;
    step(1);
    rx_restart = 1'b0;
    watch(1750, ftx, stx, frx, srx, wide);
    chk("rr_first_rx", frx, 54);
    chk("rr_first_tx", ftx, 837);
    chk("rr_tx_period", stx - ftx, 868);

    // Unsupported code
    set_baud(4'd13);
    chk("b13_valid", baud_valid, 0);
    chk("b13_k", k, 0);
    watch(10000, ftx, stx, frx, srx, wide);
    chk("b13_no_tx", ftx, -1);
    chk("b13_no_rx", frx, -1);
    set_baud(4'd4);
    chk("b13to4_k", k, 10417);
    chk("b13to4_valid", baud_valid, 1);
    watch(10500, ftx, stx, frx, srx, wide);
    chk("b13to4_first_tx", ftx, 10417);

    // enable low 100 cycles mid-count stretches one period
    set_baud(4'd8);
    step(400);
    enable = 1'b0;
    watch(100, ftx, stx, frx, srx, wide);
    chk("dis_no_tx", ftx, -1);
    chk("dis_no_rx", frx, -1);
    enable = 1'b1;
    watch(600, ftx, stx, frx, srx, wide);
    chk("en_tx_period", 400 + 100 + ftx, 968);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
